// File: rtl/pxs_vga_source.sv
// pxs_vga_source: free-running VGA timing generator driving the 23-bit Pxs stream
// (XCoord, YCoord, HSync, VSync, ActiveVideo) plus line/frame start strobes.
module pxs_vga_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        px_en,
    output logic [22:0] VGAStr_o,
    output logic        line_start_o,
    output logic        frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync end landing exactly on 1024 still compares correctly
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("pxs_vga_source: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [22:0] str_q, str_d;
    logic        ls_q, ls_d, fs_q, fs_d;
    logic        h_last, h_sync, v_sync, active;
    logic [10:0] hx, vx;

    always_comb begin
        hx     = {1'b0, hcnt_q};
        vx     = {1'b0, vcnt_q};
        h_last = hcnt_q == H_MAX;
        active = (hx < H_ACT) && (vx < V_ACT);
        h_sync = (hx >= HS_BEG) && (hx < HS_END) ? SYNC_POL : ~SYNC_POL;
        v_sync = (vx >= VS_BEG) && (vx < VS_END) ? SYNC_POL : ~SYNC_POL;
        hcnt_d = px_en ? (h_last ? 10'd0 : hcnt_q + 10'd1) : hcnt_q;
        vcnt_d = (px_en && h_last) ? (vcnt_q == V_MAX ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
        str_d  = px_en ? {hcnt_q, vcnt_q, h_sync, v_sync, active} : str_q;
        ls_d   = px_en && (hcnt_q == 10'd0);
        fs_d   = px_en && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            str_q  <= {20'd0, ~SYNC_POL, ~SYNC_POL, 1'b0};
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            str_q  <= str_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign VGAStr_o      = str_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;
endmodule

// File: tb/tb_pxs_vga_source.sv
// tb_pxs_vga_source: checks default 640x480 line timing and a small SYNC_POL=1
// instance for frame wrap, px_en gating and strobes.
module tb_pxs_vga_source;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, rst1, en1;
    logic [22:0] s0, s1;
    logic        ls0, fs0, ls1, fs1;
    int          tests = 0;
    int          fails = 0;

    pxs_vga_source d0 (
        .px_clk(clk), .reset(rst0), .px_en(en0),
        .VGAStr_o(s0), .line_start_o(ls0), .frame_start_o(fs0)
    );

    pxs_vga_source #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) d1 (
        .px_clk(clk), .reset(rst1), .px_en(en1),
        .VGAStr_o(s1), .line_start_o(ls1), .frame_start_o(fs1)
    );

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic hs, vs, av, ls, fs;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_big(input string nm, input int x, input int y, input logic ls, input logic fs);
        chk({nm, "_x"}, 32'(s0[22:13]), x);
        chk({nm, "_y"}, 32'(s0[12:3]), y);
        chk({nm, "_hs"}, 32'(s0[2]), 32'(!(x >= 656 && x < 752)));
        chk({nm, "_vs"}, 32'(s0[1]), 32'(!(y >= 490 && y < 492)));
        chk({nm, "_av"}, 32'(s0[0]), 32'(x < 640 && y < 480));
        chk({nm, "_ls"}, 32'(ls0), 32'(ls));
        chk({nm, "_fs"}, 32'(fs0), 32'(fs));
    endtask

    // Expected small-instance output after k enabled edges since reset; strobes only on enabled edges.
    task automatic chk_small(input string nm, input int k, input logic en);
        int x = k % 14;
        int y = (k / 14) % 7;
        chk({nm, "_x"}, 32'(s1[22:13]), x);
        chk({nm, "_y"}, 32'(s1[12:3]), y);
        chk({nm, "_hs"}, 32'(s1[2]), 32'(x >= 10 && x < 12));
        chk({nm, "_vs"}, 32'(s1[1]), 32'(y == 5));
        chk({nm, "_av"}, 32'(s1[0]), 32'(x < 8 && y < 4));
        chk({nm, "_ls"}, 32'(ls1), 32'(en && x == 0));
        chk({nm, "_fs"}, 32'(fs1), 32'(en && x == 0 && y == 0));
    endtask

    initial begin
        int lcnt, fcnt, k, last_fs;
        tbl[0] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (5) tick();
        chk("rst_str0", 32'(s0), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
        chk("rst_ls0", 32'(ls0), 0);
        chk("rst_fs0", 32'(fs0), 0);
        chk("rst_str1", 32'(s1), 0);
        chk("rst_ls1", 32'(ls1), 0);

        rst0 = 1'b0; en0 = 1'b1;
        lcnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            chk_big("line", i, 0, i == 0, i == 0);
            if (ls0) lcnt++;
        end
        chk("line_ls_count", lcnt, 1);
        tick();
        chk_big("line2_start", 0, 1, 1'b1, 1'b0);
        repeat (300) tick();
        chk_big("pre_areset", 300, 1, 1'b0, 1'b0);
        #4 rst0 = 1'b1;
        #1;
        chk("areset_str0", 32'(s0), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
        chk("areset_ls0", 32'(ls0), 0);
        tick();
        tick();
        rst0 = 1'b0;
        tick();
        chk_big("restart0", 0, 0, 1'b1, 1'b1);
        tick();
        chk_big("restart1", 1, 0, 1'b0, 1'b0);
        en0 = 1'b0;

        rst1 = 1'b0; en1 = 1'b1;
        lcnt = 0; fcnt = 0;
        for (int i = 0; i < 196; i++) begin
            tick();
            chk_small("frame", i, 1'b1);
            if (ls1) lcnt++;
            if (fs1) fcnt++;
        end
        chk("frame_ls_count", lcnt, 14);
        chk("frame_fs_count", fcnt, 2);

        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        k = 0;
        foreach (tbl[r]) begin
            en1 = tbl[r].en;
            tick();
            chk("tbl_x", 32'(s1[22:13]), tbl[r].x);
            chk("tbl_y", 32'(s1[12:3]), tbl[r].y);
            chk("tbl_hs", 32'(s1[2]), 32'(tbl[r].hs));
            chk("tbl_vs", 32'(s1[1]), 32'(tbl[r].vs));
            chk("tbl_av", 32'(s1[0]), 32'(tbl[r].av));
            chk("tbl_ls", 32'(ls1), 32'(tbl[r].ls));
            chk("tbl_fs", 32'(fs1), 32'(tbl[r].fs));
            if (tbl[r].en) k++;
        end

        fcnt = 0; last_fs = -1;
        for (int j = 0; j < 420; j++) begin
            en1 = (j % 4 == 0) || (j % 4 == 3);
            tick();
            if (en1) begin
                chk_small("gate_en", k, 1'b1);
                if (fs1) begin
                    fcnt++;
                    if (last_fs >= 0) chk("gate_frame_period", k - last_fs, 98);
                    last_fs = k;
                end
                k++;
            end else begin
                chk_small("gate_dis", k - 1, 1'b0);
            end
        end
        chk("gate_fs_count", fcnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
